// File: rtl/gain_ramp_scaler_if.sv
// Bundle of per-channel gain load inputs and ramped gain outputs for gain_ramp_scaler.
// master: PS register side (drives gain words and load strobes); slave: the scaler.
// sat_flag exists only when GAIN_SAT_FLAG_EN is defined.
interface gain_ramp_scaler_if #(
  parameter int NCH   = 2,
  parameter int IN_W  = 9,
  parameter int OUT_W = 9
) ();
  logic [NCH*IN_W-1:0]  gain_in;
  logic [NCH-1:0]       gain_load;
  logic [NCH*OUT_W-1:0] gain_out;
  logic [NCH-1:0]       ramping;
  logic [NCH-1:0]       done;
`ifdef GAIN_SAT_FLAG_EN
  logic [NCH-1:0]       sat_flag;

  modport master (output gain_in, gain_load, input gain_out, ramping, done, sat_flag);
  modport slave  (input gain_in, gain_load, output gain_out, ramping, done, sat_flag);
`else
  modport master (output gain_in, gain_load, input gain_out, ramping, done);
  modport slave  (input gain_in, gain_load, output gain_out, ramping, done);
`endif
endinterface

// File: rtl/gain_ramp_scaler.sv
// Per-channel gain scaler: latches gain*SCALE (saturated to OUT_W) as a target and ramps
// gain_out toward it by at most STEP per shared tick (one tick every TICK_DIV clocks).
// No backpressure; load -> first output step within TICK_DIV+1 cycles. Macro: GAIN_SAT_FLAG_EN adds sat_flag.
module gain_ramp_scaler #(
  parameter int NCH      = 2,
  parameter int IN_W     = 9,
  parameter int OUT_W    = 9,
  parameter int SCALE    = 5,
  parameter int STEP     = 1,
  parameter int TICK_DIV = 1000
) (
  input  logic          clk,
  input  logic          rst,
  gain_ramp_scaler_if.slave bus
);

  // Product is sized so gain_in*SCALE can never wrap before saturation.
  localparam int PROD_W = IN_W + $clog2(SCALE + 1);
  localparam int CMP_W  = (PROD_W > OUT_W) ? PROD_W : OUT_W;
  localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAX_I  = (2 ** OUT_W) - 1;
  localparam int STEP_C = (STEP > MAX_I) ? MAX_I : STEP;

  localparam logic [CMP_W-1:0] MAX_V    = CMP_W'(MAX_I);
  localparam logic [OUT_W-1:0] STEP_V   = OUT_W'(STEP_C);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic {S_IDLE, S_RAMP} state_e;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;

  logic [OUT_W-1:0] gain_q   [NCH];
  logic [OUT_W-1:0] gain_d   [NCH];
  logic [OUT_W-1:0] target_q [NCH];
  logic [OUT_W-1:0] target_d [NCH];
  state_e           state_q  [NCH];
  state_e           state_d  [NCH];
  logic [NCH-1:0]   done_q, done_d;

  logic [CMP_W-1:0] prod     [NCH];
  logic [OUT_W-1:0] load_val [NCH];
  logic [NCH-1:0]   over;

  // Tick marks the last cycle of each TICK_DIV-long period.
  assign tick = (cnt_q == CNT_LAST);

  // Shared tick counter: 0..TICK_DIV-1, wrapping.
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign prod[g]     = CMP_W'(bus.gain_in[g*IN_W +: IN_W]) * CMP_W'(SCALE);
    assign over[g]     = (prod[g] > MAX_V);
    assign load_val[g] = over[g] ? OUT_W'(MAX_V) : prod[g][OUT_W-1:0];

    assign bus.gain_out[g*OUT_W +: OUT_W] = gain_q[g];
    assign bus.ramping[g]                 = (state_q[g] == S_RAMP);
  end

  assign bus.done = done_q;

  // Per-channel ramp FSM: a tick step uses the old target; a same-cycle load replaces the target at
  // the same edge. State and done follow from where gain and target land after this edge.
  always_comb begin
    logic [OUT_W-1:0] diff;
    logic [OUT_W-1:0] amt;
    logic             stepped;

    gain_d   = gain_q;
    target_d = target_q;
    state_d  = state_q;
    done_d   = '0;
    diff     = '0;
    amt      = '0;
    stepped  = 1'b0;

    for (int i = 0; i < NCH; i++) begin
      diff    = (target_q[i] >= gain_q[i]) ? (target_q[i] - gain_q[i]) : (gain_q[i] - target_q[i]);
      amt     = (diff > STEP_V) ? STEP_V : diff;
      stepped = tick && (state_q[i] == S_RAMP);

      if (stepped) begin
        gain_d[i] = (target_q[i] > gain_q[i]) ? (gain_q[i] + amt) : (gain_q[i] - amt);
      end

      if (bus.gain_load[i]) begin
        target_d[i] = load_val[i];
      end

      state_d[i] = (gain_d[i] != target_d[i]) ? S_RAMP : S_IDLE;
      // Only a ramp step that lands on the (surviving) target completes a ramp.
      done_d[i]  = stepped && (gain_d[i] == target_d[i]);
    end
  end

  // State registers; reset dominates load and tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        gain_q[i]   <= '0;
        target_q[i] <= '0;
        state_q[i]  <= S_IDLE;
      end
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
      for (int i = 0; i < NCH; i++) begin
        gain_q[i]   <= gain_d[i];
        target_q[i] <= target_d[i];
        state_q[i]  <= state_d[i];
      end
    end
  end

`ifdef GAIN_SAT_FLAG_EN
  logic [NCH-1:0] sat_q, sat_d;

  // Sticky saturation indicator, refreshed by every load on the channel.
  always_comb begin
    sat_d = sat_q;
    for (int i = 0; i < NCH; i++) begin
      if (bus.gain_load[i]) begin
        sat_d[i] = over[i];
      end
    end
  end

  // Saturation flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= '0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign bus.sat_flag = sat_q;
`endif

endmodule

// File: tb/tb_gain_ramp_scaler.sv
// Self-checking bench for gain_ramp_scaler (NCH=2, IN_W=9, OUT_W=9, SCALE=5, STEP=4, TICK_DIV=3).
// Table of loads plus hand sequences for reset, mid-ramp retarget and simultaneous loads.
// Expected ramp values are queued per channel and popped whenever gain_out changes.
module tb_gain_ramp_scaler;
  localparam int NCH = 2, IN_W = 9, OUT_W = 9, SCALE = 5, STEP = 4, TICK_DIV = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gain_ramp_scaler_if #(.NCH(NCH), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  gain_ramp_scaler #(
    .NCH(NCH), .IN_W(IN_W), .OUT_W(OUT_W), .SCALE(SCALE), .STEP(STEP), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int ch;
    int gw;
    int tgt;
    int sat;
  } vec_t;

  vec_t tbl[9];
  int   nchk = 0;
  int   nerr = 0;
  int   cur[2];
  int   tgt[2];
  int   q0[$];
  int   q1[$];

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int gout(input int ch);
    return int'(bus.gain_out[ch*OUT_W +: OUT_W]);
  endfunction

  // Expected sequence of gain_out values from 'from' to 'to' in steps of at most STEP.
  task automatic push_ramp(input int ch, input int from, input int to);
    int v = from;
    while (v != to) begin
      if (to > v) v = (v + STEP > to) ? to : v + STEP;
      else        v = (v - STEP < to) ? to : v - STEP;
      if (ch == 0) q0.push_back(v);
      else         q1.push_back(v);
    end
  endtask

  task automatic load2(input logic [1:0] m, input int g0, input int g1);
    logic [IN_W-1:0] w0, w1;
    w0 = IN_W'(g0);
    w1 = IN_W'(g1);
    @(negedge clk);
    bus.gain_in   = {w1, w0};
    bus.gain_load = m;
    @(negedge clk);
    bus.gain_load = '0;
  endtask

  // Follow both channels until their expected queues drain, checking every step and done pulse.
  task automatic settle(input int exp_d0, input int exp_d1, input int budget);
    int nd[2];
    int lastc[2];
    int idle;
    int g;
    int e;
    nd    = '{0, 0};
    lastc = '{-1, -1};
    idle  = 0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      for (int ch = 0; ch < 2; ch++) begin
        g = gout(ch);
        if (g != cur[ch]) begin
          if (ch == 0 && q0.size() > 0)      e = q0.pop_front();
          else if (ch == 1 && q1.size() > 0) e = q1.pop_front();
          else                               e = cur[ch];
          chk($sformatf("ramp_value_ch%0d", ch), g, e);
          if (lastc[ch] >= 0) chk($sformatf("step_interval_ch%0d", ch), c - lastc[ch], TICK_DIV);
          else                chk($sformatf("first_step_latency_ch%0d", ch), int'(c <= TICK_DIV + 1), 1);
          lastc[ch] = c;
          cur[ch]   = g;
        end
        if (bus.done[ch]) begin
          nd[ch]++;
          chk($sformatf("done_at_target_ch%0d", ch), g, tgt[ch]);
        end
      end
      if (q0.size() == 0 && q1.size() == 0) idle++;
      if (idle > 2 * TICK_DIV) break;
    end
    chk("ramp_timeout_ch0", q0.size(), 0);
    chk("ramp_timeout_ch1", q1.size(), 0);
    q0.delete();
    q1.delete();
    chk("done_count_ch0", nd[0], exp_d0);
    chk("done_count_ch1", nd[1], exp_d1);
    chk("ramping_idle_ch0", int'(bus.ramping[0]), 0);
    chk("ramping_idle_ch1", int'(bus.ramping[1]), 0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_gain_out"}, int'(bus.gain_out), 0);
    chk({tag, "_ramping"}, int'(bus.ramping), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
`ifdef GAIN_SAT_FLAG_EN
    chk({tag, "_sat_flag"}, int'(bus.sat_flag), 0);
`endif
  endtask

  initial begin
    int found;
    vec_t v;
    logic [1:0] m;

    // {channel, gain word, saturated target, saturation expected}
    tbl[0] = '{0,  20, 100, 0};
    tbl[1] = '{0,  10,  50, 0};
    tbl[2] = '{1, 200, 511, 1};
    tbl[3] = '{1,  50, 250, 0};
    tbl[4] = '{0,  10,  50, 0};
    tbl[5] = '{1, 102, 510, 0};
    tbl[6] = '{1, 103, 511, 1};
    tbl[7] = '{0,   0,   0, 0};
    tbl[8] = '{1,   0,   0, 0};

    rst           = 1'b1;
    bus.gain_in   = '0;
    bus.gain_load = '0;
    cur           = '{0, 0};
    tgt           = '{0, 0};
    repeat (2) @(negedge clk);
    chk_reset_state("initial_reset");
    rst = 1'b0;

    // Reset in the middle of ramps on both channels.
    load2(2'b11, 100, 150);
`ifdef GAIN_SAT_FLAG_EN
    chk("sat_before_reset", int'(bus.sat_flag), 2);
`endif
    repeat (10) @(negedge clk);
    chk("active_before_reset", int'(bus.ramping), 3);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state("mid_ramp_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (3 * TICK_DIV) @(negedge clk);
    chk_reset_state("after_reset_release");

    // Table-driven loads, each followed by a full ramp check.
    for (int i = 0; i < 9; i++) begin
      v      = tbl[i];
      m      = (v.ch == 0) ? 2'b01 : 2'b10;
      load2(m, (v.ch == 0) ? v.gw : 0, (v.ch == 1) ? v.gw : 0);
      tgt[v.ch] = v.tgt;
      chk($sformatf("ramping_after_load_%0d", i), int'(bus.ramping[v.ch]), int'(v.tgt != cur[v.ch]));
      chk($sformatf("no_jump_at_load_%0d", i), gout(v.ch), cur[v.ch]);
`ifdef GAIN_SAT_FLAG_EN
      chk($sformatf("sat_flag_%0d", i), int'(bus.sat_flag[v.ch]), v.sat);
`endif
      push_ramp(v.ch, cur[v.ch], v.tgt);
      settle((v.ch == 0 && v.tgt != cur[0]) ? 1 : 0, (v.ch == 1 && v.tgt != cur[1]) ? 1 : 0, 600);
    end

    // Retarget in a tick cycle while ramping up at 40 toward 100.
    load2(2'b01, 20, 0);
    tgt[0] = 100;
    found  = 0;
    for (int c = 0; c < 100 && found == 0; c++) begin
      @(negedge clk);
      if (gout(0) == 40) found = 1;
    end
    chk("reached_40", found, 1);
    @(negedge clk);
    load2(2'b01, 6, 0);
    chk("step_with_old_target", gout(0), 44);
    chk("ramping_after_retarget", int'(bus.ramping[0]), 1);
    cur[0] = 44;
    tgt[0] = 30;
    push_ramp(0, 44, 30);
    settle(1, 0, 100);
    chk("final_after_retarget", gout(0), 30);

    // Load equal to current output: nothing happens.
    load2(2'b01, 6, 0);
    chk("equal_load_ramping", int'(bus.ramping[0]), 0);
    settle(0, 0, 50);
    chk("equal_load_value", gout(0), 30);

    // Both channels loaded in the same cycle ramp independently.
    load2(2'b11, 8, 30);
    tgt = '{40, 150};
    chk("dual_ramping", int'(bus.ramping), 3);
    push_ramp(0, cur[0], 40);
    push_ramp(1, cur[1], 150);
    settle(1, 1, 300);
    chk("dual_final_ch0", gout(0), 40);
    chk("dual_final_ch1", gout(1), 150);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
